// File: rtl/biquad_coeff_sequencer.sv
// WISHBONE master that streams a buffered coefficient set into one biquad8 wrapper
// and optionally commits it with an update write; flags bus error and ack timeout.
module biquad_coeff_sequencer #(
  parameter int unsigned NCHAN   = 16,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CHBITS = $clog2(NCHAN),
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              buf_wr_i,
  input  logic [AW-1:0]     buf_adr_i,
  input  logic [22:0]       buf_dat_i,
  input  logic              start_i,
  input  logic [CHBITS-1:0] chan_i,
  input  logic [AW:0]       count_i,
  input  logic              update_en_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [CHBITS+6:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int unsigned TOW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, UPDATE, DONE, ERROR} state_e;

  state_e              state_q, state_d;
  logic [AW:0]         idx_q, idx_d, idx_inc;
  logic [AW:0]         count_q, count_d;
  logic [CHBITS-1:0]   chan_q, chan_d;
  logic                upd_q, upd_d;
  logic [TOW-1:0]      to_q, to_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [CHBITS+6:0]   adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;

  logic [22:0]         mem [DEPTH];
  logic [22:0]         rdata_q;
  logic                rd_en;
  logic [AW-1:0]       rd_adr;
  logic                bus_clr;
  logic                resp_err, resp_ack, expired;

  // Entry 0 is read on the same edge that accepts start, so a coincident
  // buffer write to entry 0 is not seen by this sequence.
  always_ff @(posedge clk_i) begin
    if (buf_wr_i && !busy_q) mem[buf_adr_i] <= buf_dat_i;
    if (rd_en) rdata_q <= mem[rd_adr];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    chan_d   = chan_q;
    upd_d    = upd_q;
    to_d     = to_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    bus_clr  = 1'b0;
    idx_inc  = idx_q + 1'b1;
    resp_err = cyc_q & wb_err_i;
    resp_ack = cyc_q & wb_ack_i & ~wb_err_i;
    expired  = cyc_q & (to_q == TOW'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          chan_d  = chan_i;
          count_d = count_i;
          upd_d   = update_en_i;
          err_d   = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          if (count_i != '0)   state_d = FETCH;
          else if (update_en_i) state_d = UPDATE;
          else                  state_d = DONE;
        end
      end
      FETCH: begin
        state_d = WRITE;
        cyc_d   = 1'b1;
        we_d    = 1'b1;
        sel_d   = '1;
        adr_d   = {chan_q, rdata_q[22:18], 2'b00};
        dat_d   = {14'b0, rdata_q[17:0]};
        to_d    = '0;
      end
      WRITE, UPDATE: begin
        if (state_q == UPDATE && !cyc_q) begin
          // first UPDATE cycle keeps cyc low between the last entry and the commit
          cyc_d = 1'b1;
          we_d  = 1'b1;
          sel_d = '1;
          adr_d = {chan_q, 5'd0, 2'b00};
          dat_d = 32'h1;
          to_d  = '0;
        end else if (resp_err || expired) begin
          bus_clr = 1'b1;
          state_d = ERROR;
        end else if (resp_ack) begin
          bus_clr = 1'b1;
          if (state_q == UPDATE) begin
            state_d = DONE;
          end else begin
            idx_d = idx_inc;
            if (idx_inc < count_q) state_d = FETCH;
            else if (upd_q)        state_d = UPDATE;
            else                   state_d = DONE;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERROR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus_clr) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      sel_d = '0;
      adr_d = '0;
      dat_d = '0;
    end

    rd_en  = (state_d == FETCH);
    rd_adr = idx_d[AW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      chan_q  <= '0;
      upd_q   <= 1'b0;
      to_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      chan_q  <= chan_d;
      upd_q   <= upd_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Scoreboard bench for biquad_coeff_sequencer: directed sequences push expected bus
// writes; a negedge responder/monitor pops and checks each write the DUT presents.
module tb_biquad_coeff_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        buf_wr = 1'b0;
  logic [4:0]  buf_adr = '0;
  logic [22:0] buf_dat = '0;
  logic        start = 1'b0;
  logic [3:0]  chan = '0;
  logic [5:0]  count = '0;
  logic        update_en = 1'b0;
  logic        busy, done, err;
  logic        cyc, stb, we;
  logic [10:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic        berr = 1'b0;

  always #5 clk = ~clk;

  biquad_coeff_sequencer #(.NCHAN(16), .DEPTH(32), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .buf_wr_i(buf_wr), .buf_adr_i(buf_adr), .buf_dat_i(buf_dat),
    .start_i(start), .chan_i(chan), .count_i(count), .update_en_i(update_en),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel),
    .wb_ack_i(ack), .wb_err_i(berr)
  );

  typedef struct packed {
    logic [10:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  resp_mode = 0;  // 0: ack, 1: never respond, 2: ack+err on write err_at
  int  err_at = 0;
  int  wr_no = 0;
  bit  seen = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void expect_wr(logic [10:0] a, logic [31:0] d);
    wr_t w;
    w.adr = a;
    w.dat = d;
    exp_q.push_back(w);
  endfunction

  // target responder + scoreboard monitor
  always @(negedge clk) begin
    wr_t e;
    ack  = 1'b0;
    berr = 1'b0;
    if (!cyc) begin
      seen = 1'b0;
    end else if (stb && !seen) begin
      seen = 1'b1;
      wr_no++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adr=%h dat=%h expected none", adr, dat);
      end else begin
        e = exp_q.pop_front();
        chk("wb_adr", 32'(adr), 32'(e.adr));
        chk("wb_dat", dat, e.dat);
        chk("wb_we_sel", {27'b0, we, sel}, {27'b0, 1'b1, 4'hF});
      end
      case (resp_mode)
        0: ack = 1'b1;
        2: begin
          ack = 1'b1;
          if (wr_no == err_at) berr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  task automatic buf_write(input logic [4:0] a, input logic [4:0] off, input logic [17:0] c);
    @(posedge clk); #1;
    buf_wr = 1'b1; buf_adr = a; buf_dat = {off, c};
    @(posedge clk); #1;
    buf_wr = 1'b0;
  endtask

  task automatic start_seq(input logic [3:0] ch, input logic [5:0] cnt, input logic upd);
    @(posedge clk); #1;
    start = 1'b1; chan = ch; count = cnt; update_en = upd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int cyc_n, output int cyc_hi);
    bit ok;
    ok = 1'b0; cyc_n = 0; cyc_hi = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      cyc_n++;
      if (cyc) cyc_hi++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle_in_bound", 32'(ok), 32'd1);
  endtask

  initial begin
    int n, hi;
    #12;
    chk("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
    chk("rst_cyc_stb_we", {29'b0, cyc, stb, we}, 32'd0);
    chk("rst_adr_sel", {17'b0, adr, sel}, 32'd0);
    chk("rst_dat", dat, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    buf_write(5'd0, 5'd1, 18'h00123);
    buf_write(5'd1, 5'd4, 18'h3FFFF);
    buf_write(5'd2, 5'd2, 18'h00010);

    // three entries plus commit on channel 5
    wr_no = 0;
    expect_wr(11'h284, 32'h123);
    expect_wr(11'h290, 32'h3FFFF);
    expect_wr(11'h288, 32'h10);
    expect_wr(11'h280, 32'h1);
    start_seq(4'd5, 6'd3, 1'b1);
    wait_idle(100, n, hi);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_writes", 32'(wr_no), 32'd4);

    // empty sequence, no commit
    wr_no = 0;
    start_seq(4'd2, 6'd0, 1'b0);
    wait_idle(20, n, hi);
    chk("t2_latency", 32'(n), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_no_bus", 32'(wr_no + hi), 32'd0);

    // commit only, top channel
    wr_no = 0;
    expect_wr(11'h780, 32'h1);
    start_seq(4'd15, 6'd0, 1'b1);
    wait_idle(40, n, hi);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_writes", 32'(wr_no), 32'd1);

    // target never responds
    wr_no = 0; resp_mode = 1;
    expect_wr(11'h104, 32'h123);
    start_seq(4'd2, 6'd1, 1'b0);
    wait_idle(400, n, hi);
    chk("t4_cyc_cycles", 32'(hi), 32'd255);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    resp_mode = 0;
    start_seq(4'd0, 6'd0, 1'b0);
    chk("t4_err_cleared", 32'(err), 32'd0);
    wait_idle(20, n, hi);
    chk("t4_done_after", 32'(done), 32'd1);

    // ack+err together on the second of three writes
    wr_no = 0; resp_mode = 2; err_at = 2;
    expect_wr(11'h384, 32'h123);
    expect_wr(11'h390, 32'h3FFFF);
    start_seq(4'd7, 6'd3, 1'b1);
    wait_idle(100, n, hi);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_writes", 32'(wr_no), 32'd2);
    resp_mode = 0;

    // start and buffer write while busy are ignored
    wr_no = 0;
    expect_wr(11'h084, 32'h123);
    expect_wr(11'h090, 32'h3FFFF);
    expect_wr(11'h088, 32'h10);
    start_seq(4'd1, 6'd3, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; chan = 4'd9; count = 6'd1; update_en = 1'b1;
    buf_wr = 1'b1; buf_adr = 5'd2; buf_dat = {5'd9, 18'h2AAAA};
    @(posedge clk); #1;
    start = 1'b0; buf_wr = 1'b0;
    wait_idle(100, n, hi);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_writes", 32'(wr_no), 32'd3);

    // coincident start and write to entry 0: old data goes out first
    expect_wr(11'h184, 32'h123);
    @(posedge clk); #1;
    buf_wr = 1'b1; buf_adr = 5'd0; buf_dat = {5'd7, 18'h00055};
    start = 1'b1; chan = 4'd3; count = 6'd1; update_en = 1'b0;
    @(posedge clk); #1;
    buf_wr = 1'b0; start = 1'b0;
    wait_idle(40, n, hi);
    chk("t7_done_a", 32'(done), 32'd1);
    expect_wr(11'h19C, 32'h55);
    start_seq(4'd3, 6'd1, 1'b0);
    wait_idle(40, n, hi);
    chk("t7_done_b", 32'(done), 32'd1);

    // reset mid-write
    resp_mode = 1;
    expect_wr(11'h19C, 32'h55);
    start_seq(4'd3, 6'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc) break;
    end
    chk("t8_cyc_up", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_cyc_stb_async", {30'b0, cyc, stb}, 32'd0);
    chk("t8_busy_async", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    resp_mode = 0;
    repeat (3) @(negedge clk);
    chk("t8_idle_after", {30'b0, cyc, busy}, 32'd0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
